// File: rtl/feed_countdown.sv
// Repeating MM:SS countdown for the pet feeder. When the interval runs out it drives
// the dispense output for FEED_SEC seconds, reloads the preset and counts down again.
// The digit outputs feed hex-to-seven-segment decoders directly; 4'hF blanks a digit.
module feed_countdown #(
  parameter int unsigned TICK_CYCLES = 50000000,
  parameter int unsigned FEED_SEC    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cancel,
  input  logic       manual_feed,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic       dispense,
  output logic       busy,
  output logic       preset_err,
  output logic [7:0] feed_count
);

  localparam int unsigned PW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(TICK_CYCLES - 1);
  localparam logic [3:0] FeedSec   = 4'(FEED_SEC);
  localparam logic [3:0] Blank     = 4'hF;

  typedef enum logic [1:0] {StIdle, StRun, StFeed} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   reload_q, reload_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [3:0]    rem_q, rem_d;
  logic [7:0]    fc_d;
  logic          err_d;
  logic [15:0]   dig_d;
  logic          tick;
  logic          preset_ok;
  logic [15:0]   preset;

  // One-digit-at-a-time BCD decrement of {mm tens, mm ones, ss tens, ss ones}.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) begin
          r[11:8] = v[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = v[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign preset    = {preset_min, preset_sec};
  assign tick      = (state_q != StIdle) && (presc_q == PrescMax);
  assign preset_ok = (preset_min[7:4] <= 4'd9) && (preset_min[3:0] <= 4'd9) &&
                     (preset_sec[7:4] <= 4'd5) && (preset_sec[3:0] <= 4'd9) &&
                     (preset != 16'h0000);

  // Next-state logic: cancel overrides everything, manual_feed beats a same-cycle tick.
  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    fc_d     = feed_count;
    err_d    = 1'b0;
    if (cancel) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            if (preset_ok) begin
              reload_d = preset;
              cnt_d    = preset;
              state_d  = StRun;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StRun: begin
          if (manual_feed) begin
            state_d = StFeed;
            rem_d   = FeedSec;
          end else if (tick) begin
            if (cnt_q == 16'h0001) begin
              cnt_d   = 16'h0000;
              state_d = StFeed;
              rem_d   = FeedSec;
            end else begin
              cnt_d = bcd_dec(cnt_q);
            end
          end
        end
        StFeed: begin
          if (tick) begin
            if (rem_q == 4'd1) begin
              state_d = StRun;
              cnt_d   = reload_q;
              fc_d    = feed_count + 8'd1;
            end else begin
              rem_d = rem_q - 4'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Prescaler restarts on every state change so the first second is full length.
  always_comb begin
    presc_d = presc_q + 1'b1;
    if ((state_d != state_q) || (state_d == StIdle) || tick) begin
      presc_d = '0;
    end
  end

  // Display image for the next state; only the minutes tens digit is zero-blanked.
  always_comb begin
    dig_d = {Blank, Blank, Blank, Blank};
    case (state_d)
      StRun: begin
        dig_d = cnt_d;
        if (cnt_d[15:12] == 4'd0) begin
          dig_d[15:12] = Blank;
        end
      end
      StFeed:  dig_d = {Blank, Blank, Blank, rem_d};
      default: dig_d = {Blank, Blank, Blank, Blank};
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      reload_q   <= 16'h0000;
      cnt_q      <= 16'h0000;
      rem_q      <= 4'd0;
      dig3       <= Blank;
      dig2       <= Blank;
      dig1       <= Blank;
      dig0       <= Blank;
      dispense   <= 1'b0;
      busy       <= 1'b0;
      preset_err <= 1'b0;
      feed_count <= 8'd0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      reload_q   <= reload_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dig3       <= dig_d[15:12];
      dig2       <= dig_d[11:8];
      dig1       <= dig_d[7:4];
      dig0       <= dig_d[3:0];
      dispense   <= (state_d == StFeed);
      busy       <= (state_d != StIdle);
      preset_err <= err_d;
      feed_count <= fc_d;
    end
  end

endmodule

// File: tb/tb_feed_countdown.sv
// Bench for feed_countdown with TICK_CYCLES=4, FEED_SEC=2. Stimulus queues cycle-stamped
// expected output snapshots; a monitor pops and compares them on falling edges.
module tb_feed_countdown;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic       manual_feed = 1'b0;
  logic [7:0] preset_min = 8'h00;
  logic [7:0] preset_sec = 8'h00;
  logic [3:0] dig3, dig2, dig1, dig0;
  logic       dispense, busy, preset_err;
  logic [7:0] feed_count;

  feed_countdown #(
    .TICK_CYCLES(4),
    .FEED_SEC   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cancel     (cancel),
    .manual_feed(manual_feed),
    .preset_min (preset_min),
    .preset_sec (preset_sec),
    .dig3       (dig3),
    .dig2       (dig2),
    .dig1       (dig1),
    .dig0       (dig0),
    .dispense   (dispense),
    .busy       (busy),
    .preset_err (preset_err),
    .feed_count (feed_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [15:0] dig;
    logic       disp;
    logic       bsy;
    logic       err;
    logic [7:0] fc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push(input int dt, input logic [15:0] dig, input logic disp, input logic bsy,
                      input logic err, input logic [7:0] fc);
    exp_t e;
    e.at   = cyc + dt;
    e.dig  = dig;
    e.disp = disp;
    e.bsy  = bsy;
    e.err  = err;
    e.fc   = fc;
    sb.push_back(e);
  endtask

  task automatic tk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [7:0] mm, input logic [7:0] ss);
    preset_min = mm;
    preset_sec = ss;
    start      = 1'b1;
    tk(1);
    start      = 1'b0;
  endtask

  task automatic do_cancel(input logic [7:0] fc);
    push(1, 16'hFFFF, 1'b0, 1'b0, 1'b0, fc);
    cancel = 1'b1;
    tk(1);
    cancel = 1'b0;
  endtask

  // Monitor: compare every snapshot whose cycle stamp has come due.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      tests++;
      if (e.at != cyc || {dig3, dig2, dig1, dig0} !== e.dig || dispense !== e.disp ||
          busy !== e.bsy || preset_err !== e.err || feed_count !== e.fc) begin
        fails++;
        $display("FAIL snap@%0d (now %0d): got dig=%h disp=%b busy=%b err=%b fc=%0d, want dig=%h disp=%b busy=%b err=%b fc=%0d",
                 e.at, cyc, {dig3, dig2, dig1, dig0}, dispense, busy, preset_err, feed_count,
                 e.dig, e.disp, e.bsy, e.err, e.fc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tk(2);
    rst_n = 1'b1;
    push(1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'd0);
    tk(2);

    // Basic 00:03 countdown, FEED for two seconds, reload.
    push(1,  16'hF003, 1'b0, 1'b1, 1'b0, 8'd0);
    push(4,  16'hF003, 1'b0, 1'b1, 1'b0, 8'd0);
    push(5,  16'hF002, 1'b0, 1'b1, 1'b0, 8'd0);
    push(9,  16'hF001, 1'b0, 1'b1, 1'b0, 8'd0);
    push(12, 16'hF001, 1'b0, 1'b1, 1'b0, 8'd0);
    push(13, 16'hFFF2, 1'b1, 1'b1, 1'b0, 8'd0);
    push(17, 16'hFFF1, 1'b1, 1'b1, 1'b0, 8'd0);
    push(20, 16'hFFF1, 1'b1, 1'b1, 1'b0, 8'd0);
    push(21, 16'hF003, 1'b0, 1'b1, 1'b0, 8'd1);
    do_start(8'h00, 8'h03);
    tk(20);
    do_cancel(8'd1);
    tk(1);

    // Borrow chains.
    push(1, 16'h1000, 1'b0, 1'b1, 1'b0, 8'd1);
    push(5, 16'hF959, 1'b0, 1'b1, 1'b0, 8'd1);
    do_start(8'h10, 8'h00);
    tk(5);
    do_cancel(8'd1);
    push(1, 16'hF100, 1'b0, 1'b1, 1'b0, 8'd1);
    push(5, 16'hF059, 1'b0, 1'b1, 1'b0, 8'd1);
    do_start(8'h01, 8'h00);
    tk(5);
    do_cancel(8'd1);

    // Invalid presets.
    push(1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 8'd1);
    push(2, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'd1);
    do_start(8'h00, 8'h60);
    tk(2);
    push(1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 8'd1);
    push(2, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'd1);
    do_start(8'h0A, 8'h00);
    tk(2);
    push(1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 8'd1);
    push(2, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'd1);
    do_start(8'h00, 8'h00);
    tk(2);

    // cancel beats start; manual_feed ignored in IDLE.
    push(1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'd1);
    push(5, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'd1);
    preset_min = 8'h00;
    preset_sec = 8'h05;
    cancel     = 1'b1;
    start      = 1'b1;
    tk(1);
    cancel     = 1'b0;
    start      = 1'b0;
    tk(5);
    push(1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'd1);
    manual_feed = 1'b1;
    tk(1);
    manual_feed = 1'b0;
    tk(1);

    // cancel during FEED with one second left: no credit.
    push(1,  16'hF001, 1'b0, 1'b1, 1'b0, 8'd1);
    push(5,  16'hFFF2, 1'b1, 1'b1, 1'b0, 8'd1);
    push(10, 16'hFFF1, 1'b1, 1'b1, 1'b0, 8'd1);
    do_start(8'h00, 8'h01);
    tk(9);
    do_cancel(8'd1);
    push(4, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'd1);
    tk(5);

    // manual_feed at 05:29 after one tick; reload restores 05:30.
    push(1,  16'hF530, 1'b0, 1'b1, 1'b0, 8'd1);
    push(5,  16'hF529, 1'b0, 1'b1, 1'b0, 8'd1);
    push(7,  16'hFFF2, 1'b1, 1'b1, 1'b0, 8'd1);
    push(11, 16'hFFF1, 1'b1, 1'b1, 1'b0, 8'd1);
    push(15, 16'hF530, 1'b0, 1'b1, 1'b0, 8'd2);
    push(19, 16'hF529, 1'b0, 1'b1, 1'b0, 8'd2);
    do_start(8'h05, 8'h30);
    tk(5);
    manual_feed = 1'b1;
    tk(1);
    manual_feed = 1'b0;
    tk(12);

    // Asynchronous reset mid-RUN, applied right after a rising edge.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    push(0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'd0);
    tk(1);
    rst_n = 1'b1;
    push(1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'd0);
    tk(2);

    // 256 completed feeds at 12 cycles each wrap feed_count to 0.
    push(1,            16'hF001, 1'b0, 1'b1, 1'b0, 8'd0);
    push(13,           16'hF001, 1'b0, 1'b1, 1'b0, 8'd1);
    push(1 + 12 * 255, 16'hF001, 1'b0, 1'b1, 1'b0, 8'd255);
    push(12 * 256,     16'hFFF1, 1'b1, 1'b1, 1'b0, 8'd255);
    push(1 + 12 * 256, 16'hF001, 1'b0, 1'b1, 1'b0, 8'd0);
    do_start(8'h00, 8'h01);
    tk(12 * 256 + 2);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d snapshots unchecked, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
